// File: rtl/ioctl_word_unpacker_if.sv
// Word-in / byte-out bundle between the HPS ioctl download port and the ROM download path.
interface ioctl_word_unpacker_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wr;
  logic        dl_active;
  logic        dl_done;
  logic [24:0] dl_bytes;
  logic [15:0] dl_sum;
  logic        overflow;

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, dl_addr, dl_data, dl_wr, dl_active, dl_done,
           dl_bytes, dl_sum, overflow
  );

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, dl_addr, dl_data, dl_wr, dl_active, dl_done,
           dl_bytes, dl_sum, overflow
  );
endinterface

// File: rtl/ioctl_word_unpacker.sv
// Buffers 16-bit ioctl download words in a small FIFO and replays each as two byte writes,
// with backpressure, progress/checksum counters and a sticky completion flag.
module ioctl_word_unpacker #(
  parameter int          DEPTH   = 4,
  parameter logic [24:0] ROM_END = 25'he0000
) (
  input logic             clk,
  input logic             reset_n,
  ioctl_word_unpacker_if.slave io
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } word_t;

  typedef enum logic [1:0] {IDLE, LO, HI} state_e;

  word_t          mem_q [DEPTH];
  logic [AW-1:0]  wp_q, rp_q, rp_nxt;
  logic [CW-1:0]  cnt_q, cnt_d;
  state_e         state_q, state_d;

  logic           push, pop, full, ovf_ev;
  word_t          in_word, head, src;
  logic           ld, fwd;
  logic [24:0]    byte_addr;
  logic [7:0]     byte_data;

  logic [24:0]    dl_addr_q, dl_bytes_q, dl_bytes_d;
  logic [7:0]     dl_data_q;
  logic [15:0]    dl_sum_q, dl_sum_d;
  logic           dl_wr_q, wait_q, active_q, active_d, act_dly_q;
  logic           done_q, done_d, ovf_q, ovf_d, dnld_q, start;

  assign full    = (cnt_q == CW'(DEPTH));
  assign push    = io.ioctl_wr & io.ioctl_download & ~full;
  assign ovf_ev  = io.ioctl_wr & io.ioctl_download & full;
  assign pop     = (state_q == HI);
  assign in_word = '{addr: {io.ioctl_addr[24:1], 1'b0}, data: io.ioctl_dout};
  assign rp_nxt  = rp_q + AW'(1);
  assign head    = mem_q[rp_q];
  assign start   = io.ioctl_download & ~dnld_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Byte outputs are loaded on the edge that enters LO/HI. Leaving HI straight into LO
  // needs the entry behind the head, which is the incoming word when only one is queued.
  always_comb begin
    state_d   = state_q;
    src       = head;
    ld        = 1'b0;
    byte_addr = '0;
    byte_data = '0;
    case (state_q)
      IDLE: if (cnt_q != '0) state_d = LO;
      LO:   state_d = HI;
      HI: begin
        if (cnt_d != '0) begin
          state_d = LO;
          src     = (cnt_q > CW'(1)) ? mem_q[rp_nxt] : in_word;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == LO) begin
      ld        = 1'b1;
      byte_addr = src.addr;
      byte_data = src.data[7:0];
    end else if (state_d == HI) begin
      ld        = 1'b1;
      byte_addr = {head.addr[24:1], 1'b1};
      byte_data = head.data[15:8];
    end
  end

  assign fwd        = ld & (byte_addr < ROM_END);
  assign dl_bytes_d = (start ? 25'd0 : dl_bytes_q) + {24'd0, fwd};
  assign dl_sum_d   = (start ? 16'd0 : dl_sum_q) + (fwd ? {8'd0, byte_data} : 16'd0);
  assign active_d   = io.ioctl_download | (cnt_d != '0) | (state_d != IDLE);
  assign done_d     = ~start & (done_q | (act_dly_q & ~active_q));
  assign ovf_d      = (ovf_q & ~start) | ovf_ev;

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      dl_addr_q  <= '0;
      dl_data_q  <= '0;
      dl_wr_q    <= 1'b0;
      dl_bytes_q <= '0;
      dl_sum_q   <= '0;
      wait_q     <= 1'b0;
      active_q   <= 1'b0;
      act_dly_q  <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      dnld_q     <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_nxt;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      if (ld) begin
        dl_addr_q <= byte_addr;
        dl_data_q <= byte_data;
      end
      dl_wr_q    <= fwd;
      dl_bytes_q <= dl_bytes_d;
      dl_sum_q   <= dl_sum_d;
      wait_q     <= (cnt_d >= CW'(DEPTH - 1));
      active_q   <= active_d;
      act_dly_q  <= active_q;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      dnld_q     <= io.ioctl_download;
    end
  end

  assign io.ioctl_wait = wait_q;
  assign io.dl_addr    = dl_addr_q;
  assign io.dl_data    = dl_data_q;
  assign io.dl_wr      = dl_wr_q;
  assign io.dl_active  = active_q;
  assign io.dl_done    = done_q;
  assign io.dl_bytes   = dl_bytes_q;
  assign io.dl_sum     = dl_sum_q;
  assign io.overflow   = ovf_q;
endmodule
